// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Computes a WIDTH-bit add or subtract with a single 4-bit ripple slice.
//   The slice is stepped over the operands one nibble per clock, starting
//   with the least-significant nibble. A start/busy/done handshake connects
//   the block to the control logic that issues operations.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request; taken only in IDLE or DONE
//   sub        0 = A+B, 1 = A-B; captured with start
//   op_a/op_b  operands; captured with start
//   busy       high while an operation is running
//   done       one-cycle pulse; result and flags are valid
//   result     sum/difference; held until the next accepted start
//   carry_out  carry out of the MSB (1 = no borrow when subtracting)
//   overflow   signed two's-complement overflow
module nibble_serial_adder_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned SLICE      = 4;
  localparam int unsigned NUM_SLICES = WIDTH / SLICE;
  localparam int unsigned CW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CW-1:0] LAST     = CW'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // B already inverted for subtraction
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic [SLICE:0]   slice_c;

  // Select the nibble pair addressed by the slice counter.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      if (cnt_q == CW'(i)) begin
        slice_a = a_q[i*SLICE +: SLICE];
        slice_b = b_q[i*SLICE +: SLICE];
      end
    end
  end

  // 4-bit ripple chain of full adders; carry-in comes from the carry register.
  always_comb begin
    slice_sum  = '0;
    slice_c    = '0;
    slice_c[0] = carry_q;
    for (int unsigned i = 0; i < SLICE; i++) begin
      slice_sum[i]  = slice_a[i] ^ slice_b[i] ^ slice_c[i];
      slice_c[i+1]  = (slice_a[i] & slice_b[i]) | (slice_c[i] & (slice_a[i] ^ slice_b[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is A + ~B + 1: invert B once here, seed carry with sub.
          a_d      = op_a;
          b_d      = op_b ^ {WIDTH{sub}};
          carry_d  = sub;
          result_d = '0;
          cnt_d    = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NUM_SLICES; i++) begin
          if (cnt_q == CW'(i)) begin
            result_d[i*SLICE +: SLICE] = slice_sum;
          end
        end
        carry_d = slice_c[SLICE];
        if (cnt_q == LAST) begin
          // Final slice: its sum MSB is the result MSB.
          cout_d  = slice_c[SLICE];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[SLICE-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
//   Directed bench for nibble_serial_adder_ctrl at WIDTH = 32 with
//   hand-computed expected values.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  nibble_serial_adder_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and returns in the done cycle (or after a 20-cycle
  // bound). lat = edges from acceptance to done; nbusy = busy cycles seen.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int lat, output int nbusy);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; sub = 1'b1;
    lat = 0; nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    tick(); tick();
    rst = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 00000000", result); end
    tests++; if ({carry_out, overflow} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {carry_out, overflow}); end
  endtask

  task automatic test_basic_add();
    int lat, nb;
    do_op(32'h0000000F, 32'h00000001, 1'b0, lat, nb);
    tests++; if (lat !== 8) begin fails++; $display("FAIL basic_latency got %0d want 8", lat); end
    tests++; if (nb !== 8) begin fails++; $display("FAIL basic_busy_cycles got %0d want 8", nb); end
    tests++; if (result !== 32'h00000010) begin fails++; $display("FAIL basic_result got %h want 00000010", result); end
    tests++; if ({carry_out, overflow} !== 2'b00) begin fails++; $display("FAIL basic_flags got %b want 00", {carry_out, overflow}); end
    tick();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_single got %b want 0", done); end
    repeat (5) tick();
    tests++; if (result !== 32'h00000010) begin fails++; $display("FAIL basic_hold got %h want 00000010", result); end
  endtask

  task automatic test_carry_ripple();
    int lat, nb;
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, nb);
    tests++; if (result !== 32'h00000000) begin fails++; $display("FAIL ripple_result got %h want 00000000", result); end
    tests++; if ({carry_out, overflow} !== 2'b10) begin fails++; $display("FAIL ripple_flags got %b want 10", {carry_out, overflow}); end
    tick();
  endtask

  task automatic test_subtract();
    int lat, nb;
    do_op(32'd5, 32'd7, 1'b1, lat, nb);
    tests++; if (result !== 32'hFFFFFFFE) begin fails++; $display("FAIL sub_5m7_result got %h want fffffffe", result); end
    tests++; if ({carry_out, overflow} !== 2'b00) begin fails++; $display("FAIL sub_5m7_flags got %b want 00", {carry_out, overflow}); end
    tick();
    do_op(32'd7, 32'd5, 1'b1, lat, nb);
    tests++; if (result !== 32'h00000002) begin fails++; $display("FAIL sub_7m5_result got %h want 00000002", result); end
    tests++; if ({carry_out, overflow} !== 2'b10) begin fails++; $display("FAIL sub_7m5_flags got %b want 10", {carry_out, overflow}); end
    tick();
  endtask

  task automatic test_overflow();
    int lat, nb;
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat, nb);
    tests++; if (result !== 32'h80000000) begin fails++; $display("FAIL ovf_add_result got %h want 80000000", result); end
    tests++; if ({carry_out, overflow} !== 2'b01) begin fails++; $display("FAIL ovf_add_flags got %b want 01", {carry_out, overflow}); end
    tick();
    do_op(32'h80000000, 32'h00000001, 1'b1, lat, nb);
    tests++; if (result !== 32'h7FFFFFFF) begin fails++; $display("FAIL ovf_sub_result got %h want 7fffffff", result); end
    tests++; if ({carry_out, overflow} !== 2'b11) begin fails++; $display("FAIL ovf_sub_flags got %b want 11", {carry_out, overflow}); end
    // Flags from the previous op must clear when the next op is accepted.
    tick();
    op_a = 32'h1; op_b = 32'h1; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if ({carry_out, overflow} !== 2'b00) begin fails++; $display("FAIL accept_clears_flags got %b want 00", {carry_out, overflow}); end
    repeat (10) tick();
  endtask

  task automatic test_back_to_back();
    int lat, gap;
    op_a = 32'h12345678; op_b = 32'h11111111; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    repeat (3) begin tick(); lat++; end
    // Start during RUN with different operands: must be ignored.
    op_a = 32'hDEADBEEF; op_b = 32'h0BADF00D; sub = 1'b1; start = 1'b1;
    tick(); lat++;
    start = 1'b0;
    while (!done && lat < 20) begin tick(); lat++; end
    tests++; if (lat !== 8) begin fails++; $display("FAIL run_start_latency got %0d want 8", lat); end
    tests++; if (result !== 32'h23456789) begin fails++; $display("FAIL run_start_result got %h want 23456789", result); end
    // Start held during DONE: accepted immediately.
    op_a = 32'h00000100; op_b = 32'h00000001; sub = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    gap = 1;
    tests++; if ({busy, done} !== 2'b10) begin fails++; $display("FAIL b2b_no_idle got busy,done=%b want 10", {busy, done}); end
    while (!done && gap < 20) begin tick(); gap++; end
    tests++; if (gap !== 9) begin fails++; $display("FAIL b2b_done_spacing got %0d want 9", gap); end
    tests++; if (result !== 32'h000000FF) begin fails++; $display("FAIL b2b_result got %h want 000000ff", result); end
    tests++; if (carry_out !== 1'b1) begin fails++; $display("FAIL b2b_carry got %b want 1", carry_out); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int lat, nb, seen;
    op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL midrst_ctrl got busy,done=%b want 00", {busy, done}); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL midrst_result got %h want 00000000", result); end
    tests++; if ({carry_out, overflow} !== 2'b00) begin fails++; $display("FAIL midrst_flags got %b want 00", {carry_out, overflow}); end
    seen = 0;
    repeat (12) begin
      tick();
      if (done) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_done got %0d pulses want 0", seen); end
    do_op(32'h0F0F0F0F, 32'h01010101, 1'b0, lat, nb);
    tests++; if (lat !== 8) begin fails++; $display("FAIL post_rst_latency got %0d want 8", lat); end
    tests++; if (result !== 32'h10101010) begin fails++; $display("FAIL post_rst_result got %h want 10101010", result); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_ripple();
    test_subtract();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that computes a WIDTH-bit add or subtract by stepping one 4-bit ripple slice (half/full-adder chain with carry-in/carry-out) over the operands, one nibble per clock, LSB nibble first. It trades latency for area and serves low-throughput integer paths such as address offset and loop-counter updates. A start/busy/done handshake connects it to the issuing control logic.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8.
SLICE, 4, slice width in bits; fixed at 4, not overridable in use.
NUM_SLICES, WIDTH/SLICE, derived; number of RUN cycles.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when the block accepts (IDLE or DONE)
sub  input  1  0 = A+B, 1 = A−B; sampled with start
op_a  input  WIDTH  operand A; sampled with start
op_b  input  WIDTH  operand B; sampled with start
busy  output  1  high while the FSM is in RUN
done  output  1  one-cycle pulse; result/flags valid
result  output  WIDTH  sum/difference; held until the next accepted start
carry_out  output  1  carry out of the MSB (1 = no borrow when sub=1)
overflow  output  1  signed two's-complement overflow

Behaviour:
- Single clock domain. rst is synchronous and active-high.
- Reset values: state = IDLE; busy = 0; done = 0; result = 0; carry_out = 0; overflow = 0; slice counter = 0; carry register = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start = 1, latch op_a, op_b and sub; clear result; set the carry register to sub; set counter = 0; go to RUN. Otherwise stay in IDLE.
  - RUN: each cycle, slice index = counter.
    - Slice inputs are A[4i+3:4i] and (B[4i+3:4i] XOR {4{sub}}), plus the carry register.
    - Write the slice sum to result[4i+3:4i]. Load the slice carry-out into the carry register. Increment counter.
    - On the cycle processing slice NUM_SLICES−1, also register carry_out and overflow, then go to DONE.
  - DONE: done = 1 for exactly this cycle. Next state is IDLE, unless start = 1, which is accepted exactly as from IDLE (back-to-back operation, no dead cycle).
- start while in RUN is ignored: no queueing, no effect on the operation in flight.
- Latency: start accepted at edge k → done = 1 during the cycle following edge k+NUM_SLICES. With WIDTH = 32 that is 8 cycles.
- Throughput: one operation per NUM_SLICES+1 cycles when issued back-to-back.
- Flags:
  - overflow = (A[MSB] == Beff[MSB]) AND (result[MSB] != A[MSB]), where Beff is the inverted B when sub = 1.
  - carry_out is the raw carry out of the final slice.
- Intermediate result bits are visible while busy = 1 but are not valid. Consumers sample only on done, or hold the value afterwards.
- Flags and result hold their values in IDLE until the next accepted start. carry_out and overflow are cleared at accept.
- Operand inputs may change freely after acceptance; internal copies are used.
- rst asserted in any state, including mid-RUN, returns all outputs to their reset values on that edge. The operation in flight is discarded and no done pulse is produced.
- The counter never wraps past NUM_SLICES−1. The RUN exit is by comparison, not by overflow of the counter.

Test Plan:
- WIDTH = 32, start with op_a = 0x0000000F, op_b = 0x00000001, sub = 0 → busy high for 8 cycles; done pulses once; result = 0x00000010, carry_out = 0, overflow = 0; result still held 5 cycles later.
- op_a = 0xFFFFFFFF, op_b = 0x00000001, sub = 0 → result = 0x00000000, carry_out = 1, overflow = 0 (carry ripples through all 8 slices).
- op_a = 5, op_b = 7, sub = 1 → result = 0xFFFFFFFE, carry_out = 0, overflow = 0. Then 7−5 → result = 0x00000002, carry_out = 1.
- op_a = 0x7FFFFFFF + 0x00000001 → result = 0x80000000, overflow = 1. Then 0x80000000 − 1 → result = 0x7FFFFFFF, overflow = 1.
- Pulse start with new operands at RUN cycle 3 → ignored; the first result completes unchanged. Then hold start high during the DONE cycle → second op accepted with no IDLE cycle, and done arrives exactly 9 cycles after the first done.
- Assert rst for 1 cycle at RUN cycle 4 → next cycle busy = 0, done = 0, result = 0, flags = 0; no done pulse follows. A fresh start afterwards computes correctly.
